// File: rtl/key_search_pkg.sv
// key_search_pkg: shared state type, defaults and index-width helper for the key search coordinator.
package key_search_pkg;
    typedef enum logic [2:0] {IDLE, LAUNCH, SEARCH, FOUND, EXHAUSTED} ks_state_t;
    localparam int KEY_WIDTH_DEF = 24;
    localparam int SEARCH_WIDTH_DEF = 22;
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/success_priority_encoder.sv
// success_priority_encoder: lowest-index-first request encoder.
module success_priority_encoder
    import key_search_pkg::*;
#(
    parameter int N = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    output logic          any,
    output logic [IW-1:0] index
);
    always_comb begin
        any = |req;
        index = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) index = IW'(i);
    end
endmodule

// File: rtl/key_search_coordinator.sv
// key_search_coordinator: partitions the key space over the cores, launches them,
// arbitrates hits and reports the winning key, exhaustion and search duration.
module key_search_coordinator
    import key_search_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int KEY_WIDTH = KEY_WIDTH_DEF,
    parameter int SEARCH_WIDTH = SEARCH_WIDTH_DEF,
    parameter int CYCLE_WIDTH = 32,
    localparam int IW = idx_width(NUM_CORES)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic                           core_start,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_base_key,
    output logic [SEARCH_WIDTH-1:0]        core_key_count,
    output logic                           core_abort,
    input  logic [NUM_CORES-1:0]           core_success,
    input  logic [NUM_CORES-1:0]           core_fail,
    input  logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    output logic                           busy,
    output logic                           found_valid,
    output logic [KEY_WIDTH-1:0]           found_key,
    output logic [IW-1:0]                  found_core,
    output logic                           all_failed,
    output logic [CYCLE_WIDTH-1:0]         elapsed_cycles
);
    localparam logic [63:0] SLICE = (64'd1 << SEARCH_WIDTH) / 64'(NUM_CORES);
    localparam logic [KEY_WIDTH-1:0] KEY_MASK = KEY_WIDTH'((64'd1 << SEARCH_WIDTH) - 64'd1);

    ks_state_t            state;
    logic [NUM_CORES-1:0] fail_mask;
    logic                 hit;
    logic [IW-1:0]        hit_idx;
    logic [KEY_WIDTH-1:0] hit_key;

    success_priority_encoder #(.N(NUM_CORES), .IW(IW)) u_enc (
        .req(core_success), .any(hit), .index(hit_idx)
    );

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_part
        assign core_base_key[i*KEY_WIDTH +: KEY_WIDTH] = KEY_WIDTH'(64'(i) * SLICE);
    end
    assign core_key_count = SEARCH_WIDTH'(SLICE - 64'd1);

    always_comb begin
        hit_key = '0;
        for (int i = 0; i < NUM_CORES; i++)
            if (IW'(i) == hit_idx) hit_key = core_key[i*KEY_WIDTH +: KEY_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            core_start <= 1'b0;
            core_abort <= 1'b0;
            busy <= 1'b0;
            found_valid <= 1'b0;
            found_key <= '0;
            found_core <= '0;
            all_failed <= 1'b0;
            elapsed_cycles <= '0;
            fail_mask <= '0;
        end else begin
            case (state)
                IDLE, FOUND, EXHAUSTED: if (start) begin
                    // results are cleared on entry so LAUNCH already shows a clean slate
                    state <= LAUNCH;
                    core_start <= 1'b1;
                    core_abort <= 1'b0;
                    found_valid <= 1'b0;
                    found_key <= '0;
                    found_core <= '0;
                    all_failed <= 1'b0;
                    elapsed_cycles <= '0;
                    fail_mask <= '0;
                end
                LAUNCH: begin
                    state <= SEARCH;
                    core_start <= 1'b0;
                    busy <= 1'b1;
                end
                SEARCH: begin
                    elapsed_cycles <= elapsed_cycles + CYCLE_WIDTH'(!(&elapsed_cycles));
                    fail_mask <= fail_mask | core_fail;
                    if (hit) begin
                        state <= FOUND;
                        busy <= 1'b0;
                        core_abort <= 1'b1;
                        found_valid <= 1'b1;
                        found_key <= hit_key & KEY_MASK;
                        found_core <= hit_idx;
                    end else if (&(fail_mask | core_fail)) begin
                        state <= EXHAUSTED;
                        busy <= 1'b0;
                        core_abort <= 1'b1;
                        all_failed <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_search_coordinator.sv
// tb_key_search_coordinator: randomized and directed search scenarios against a timeline model.
module tb_key_search_coordinator;
    localparam int N = 4, KW = 24, SW = 22, CWD = 32, MAXC = 300;
    localparam logic [63:0] SPACE = 64'd1 << SW;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic core_start, core_abort, busy, found_valid, all_failed;
    logic [N*KW-1:0] core_base_key, core_key = '0;
    logic [SW-1:0] core_key_count;
    logic [N-1:0] core_success = '0, core_fail = '0;
    logic [KW-1:0] found_key;
    logic [1:0] found_core;
    logic [CWD-1:0] elapsed_cycles;

    logic u1_cs, u1_ab, u1_busy, u1_fv, u1_af, u1_fc;
    logic [KW-1:0] u1_base, u1_fk;
    logic [SW-1:0] u1_cnt;
    logic [CWD-1:0] u1_el;
    logic u8_cs, u8_ab, u8_busy, u8_fv, u8_af;
    logic [8*KW-1:0] u8_base;
    logic [KW-1:0] u8_fk;
    logic [2:0] u8_fc;
    logic [SW-1:0] u8_cnt;
    logic [CWD-1:0] u8_el;

    int checks = 0, failures = 0;
    int succ_t[N], fail_t[N];
    logic [KW-1:0] keys[N];
    bit pulse;

    always #5 clk = ~clk;

    key_search_coordinator #(.NUM_CORES(N)) dut (
        .clk(clk), .reset(reset), .start(start), .core_start(core_start),
        .core_base_key(core_base_key), .core_key_count(core_key_count), .core_abort(core_abort),
        .core_success(core_success), .core_fail(core_fail), .core_key(core_key), .busy(busy),
        .found_valid(found_valid), .found_key(found_key), .found_core(found_core),
        .all_failed(all_failed), .elapsed_cycles(elapsed_cycles)
    );

    key_search_coordinator #(.NUM_CORES(1)) u1 (
        .clk(clk), .reset(reset), .start(1'b0), .core_start(u1_cs), .core_base_key(u1_base),
        .core_key_count(u1_cnt), .core_abort(u1_ab), .core_success(1'b0), .core_fail(1'b0),
        .core_key('0), .busy(u1_busy), .found_valid(u1_fv), .found_key(u1_fk),
        .found_core(u1_fc), .all_failed(u1_af), .elapsed_cycles(u1_el)
    );

    key_search_coordinator #(.NUM_CORES(8)) u8 (
        .clk(clk), .reset(reset), .start(1'b0), .core_start(u8_cs), .core_base_key(u8_base),
        .core_key_count(u8_cnt), .core_abort(u8_ab), .core_success(8'h00), .core_fail(8'h00),
        .core_key('0), .busy(u8_busy), .found_valid(u8_fv), .found_key(u8_fk),
        .found_core(u8_fc), .all_failed(u8_af), .elapsed_cycles(u8_el)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_scn();
        for (int i = 0; i < N; i++) begin
            succ_t[i] = 0;
            fail_t[i] = 0;
            keys[i] = KW'($urandom);
        end
        pulse = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_core_abort"}, core_abort, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_found_valid"}, found_valid, 0);
        chk({tag, "_found_key"}, found_key, 0);
        chk({tag, "_found_core"}, found_core, 0);
        chk({tag, "_all_failed"}, all_failed, 0);
        chk({tag, "_elapsed"}, elapsed_cycles, 0);
    endtask

    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        core_success = '0;
        core_fail = '0;
        for (int i = 0; i < N; i++) core_key[i*KW +: KW] = keys[i];
        @(negedge clk);
        start = 1'b0;
        chk("launch_core_start", core_start, 1);
        chk("launch_busy", busy, 0);
        chk("launch_found_valid", found_valid, 0);
        chk("launch_core_abort", core_abort, 0);
        chk("launch_all_failed", all_failed, 0);
        chk("launch_elapsed", elapsed_cycles, 0);
    endtask

    // Model: walk the event timeline; the first cycle with any success wins
    // (lowest core), otherwise the first cycle by which every core has failed.
    task automatic run_trial();
        int end_k = 0, win = -1;
        bit ex;
        for (int k = 1; k <= MAXC && end_k == 0; k++) begin
            for (int i = N - 1; i >= 0; i--)
                if (succ_t[i] != 0 && succ_t[i] <= k) win = i;
            ex = 1'b1;
            for (int i = 0; i < N; i++)
                if (fail_t[i] == 0 || fail_t[i] > k) ex = 1'b0;
            if (win >= 0 || ex) end_k = k;
        end
        launch();
        for (int k = 1; k <= end_k; k++) begin
            @(negedge clk);
            if (k == 1) chk("search_core_start", core_start, 0);
            chk("search_busy", busy, 1);
            chk("search_abort", core_abort, 0);
            start = 1'($urandom);
            for (int i = 0; i < N; i++) begin
                core_success[i] = succ_t[i] != 0 && succ_t[i] <= k;
                core_fail[i] = pulse ? (fail_t[i] == k) : (fail_t[i] != 0 && fail_t[i] <= k);
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("end_found_valid", found_valid, win >= 0);
        chk("end_all_failed", all_failed, win < 0);
        chk("end_core_abort", core_abort, 1);
        chk("end_busy", busy, 0);
        chk("end_elapsed", elapsed_cycles, end_k);
        chk("end_found_core", found_core, win >= 0 ? win : 0);
        chk("end_found_key", found_key, win >= 0 ? (keys[win] & ((1 << SW) - 1)) : 0);
        core_fail = '0;
        repeat (3) @(negedge clk);
        chk("hold_elapsed", elapsed_cycles, end_k);
        chk("hold_abort", core_abort, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        for (int i = 0; i < N; i++)
            chk("base4", core_base_key[i*KW +: KW], SPACE / N * i);
        chk("count4", core_key_count, SPACE / N - 1);
        chk("base1", u1_base, 0);
        chk("count1", u1_cnt, SPACE - 1);
        for (int i = 0; i < 8; i++)
            chk("base8", u8_base[i*KW +: KW], SPACE / 8 * i);
        chk("count8", u8_cnt, SPACE / 8 - 1);
        reset = 1'b0;

        clear_scn();
        succ_t[2] = 100; keys[2] = 24'h2ABCDE;
        run_trial();
        clear_scn();
        succ_t[1] = 7; succ_t[3] = 7; keys[1] = 24'hC12345;
        run_trial();
        chk("key_masked", found_key, 24'h012345);
        clear_scn();
        fail_t = '{10, 20, 30, 40};
        run_trial();
        clear_scn();
        fail_t = '{10, 20, 30, 40}; pulse = 1'b1;
        run_trial();
        clear_scn();
        fail_t = '{10, 20, 30, 40}; succ_t[0] = 40;
        run_trial();
        chk("coincident_found", found_core, 0);

        for (int t = 0; t < 40; t++) begin
            clear_scn();
            for (int i = 0; i < N; i++) begin
                fail_t[i] = $urandom_range(1, 60);
                succ_t[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : 0;
            end
            pulse = 1'($urandom);
            run_trial();
        end

        clear_scn();
        launch();
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_zero("midreset");
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
